fetch_stage: RTL and testbench

Instruction-fetch stage of the five-stage pipelined processor: owns the program counter, drives the instruction-memory address, and registers the fetched word into the F/D latch consumed by the decode stage's register-read control. Honours a decode-side stall (load-use or multdiv hazard) and a redirect from the execute stage (taken branch, jump, jal, jr, bex). Flushed slots become the all-zero instruction, which decodes as a harmless add to $0.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/fd_latch.sv | 37 +++
 rtl/fetch_stage.sv | 85 ++++++++
 tb/tb_fetch_stage.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared processor definitions: instruction width, canonical bubble word, opcode field, reset vector.
// Constants only; no logic or flow control.
package cpu_pkg;

    localparam int          INSN_W           = 32;
    localparam int          ADDR_W           = 32;
    localparam logic [31:0] NOP_INSN         = 32'h0000_0000;
    localparam int          OPCODE_MSB       = 31;
    localparam int          OPCODE_LSB       = 27;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'd0;

    typedef logic [OPCODE_MSB-OPCODE_LSB:0] opcode_t;

    function automatic opcode_t insnOpcode(input logic [INSN_W-1:0] insn);
        return insn[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/fd_latch.sv
// F/D pipeline register: instruction, its PC, PC+1 and a valid bit.
// Latency 1 cycle; hold freezes all fields, flush (priority over hold) injects a bubble but keeps the PCs.
module fd_latch
    import cpu_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              hold,
    input  logic              flush,
    input  logic [INSN_W-1:0] nextInsn,
    input  logic [ADDR_W-1:0] nextPc,
    input  logic [ADDR_W-1:0] nextPcPlus1,
    output logic [INSN_W-1:0] insn,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pcPlus1,
    output logic              valid
);

    always_ff @(posedge clock) begin
        if (reset) begin
            insn    <= NOP_INSN;
            pc      <= '0;
            pcPlus1 <= '0;
            valid   <= 1'b0;
        end else if (flush) begin
            // Bubble decodes as add $0; PCs are left alone since a bubble never uses them.
            insn  <= NOP_INSN;
            valid <= 1'b0;
        end else if (!hold) begin
            insn    <= nextInsn;
            pc      <= nextPc;
            pcPlus1 <= nextPcPlus1;
            valid   <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, imem address, F/D latch; perf counters when FETCH_PERF_EN is defined.
// Latency 1 cycle fetch-to-decode; address_imem is combinational from the PC register only.
// Priority reset > redirect > stall > advance; stall freezes PC and F/D, redirect flushes F/D.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    output logic [ADDR_W-1:0] address_imem,
    input  logic [INSN_W-1:0] q_imem,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [INSN_W-1:0] fd_insn,
    output logic [ADDR_W-1:0] fd_pc,
    output logic [ADDR_W-1:0] fd_pc_plus1,
    output logic              fd_valid,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_stalls,
    output logic [31:0]       perf_flushes
);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pcPlus1;
    logic              advance;

    assign pcPlus1      = pc + 32'd1;   // wraps 32'hFFFFFFFF -> 0 by truncation
    assign advance      = !redirect && !stall;
    assign address_imem = pc;

    always_ff @(posedge clock) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= redirect_pc;
        end else if (!stall) begin
            pc <= pcPlus1;
        end
    end

    fd_latch u_fdLatch (
        .clock       (clock),
        .reset       (reset),
        .hold        (stall),
        .flush       (redirect),
        .nextInsn    (q_imem),
        .nextPc      (pc),
        .nextPcPlus1 (pcPlus1),
        .insn        (fd_insn),
        .pc          (fd_pc),
        .pcPlus1     (fd_pc_plus1),
        .valid       (fd_valid)
    );

`ifdef FETCH_PERF_EN
    logic [31:0] fetchedCnt;
    logic [31:0] stallCnt;
    logic [31:0] flushCnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            fetchedCnt <= '0;
            stallCnt   <= '0;
            flushCnt   <= '0;
        end else begin
            if (advance)            fetchedCnt <= fetchedCnt + 32'd1;
            if (stall && !redirect) stallCnt   <= stallCnt + 32'd1;
            if (redirect)           flushCnt   <= flushCnt + 32'd1;
        end
    end

    assign perf_fetched = fetchedCnt;
    assign perf_stalls  = stallCnt;
    assign perf_flushes = flushCnt;
`else
    logic unusedAdvance;
    assign unusedAdvance = advance;
    assign perf_fetched  = '0;
    assign perf_stalls   = '0;
    assign perf_flushes  = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized control against a rule-level model.
module tb_fetch_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] qXor = '0;

    logic [31:0] address_imem, q_imem, fd_insn, fd_pc, fd_pc_plus1;
    logic        fd_valid;
    logic [31:0] perf_fetched, perf_stalls, perf_flushes;

    logic [31:0] address_imem2, q_imem2, fd_insn2, fd_pc2, fd_pc_plus12;
    logic        fd_valid2;
    logic [31:0] perf_fetched2, perf_stalls2, perf_flushes2;

    int total = 0;
    int bad   = 0;

`ifdef FETCH_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    function automatic logic [31:0] rom(input logic [31:0] a);
        return a + 32'h100;
    endfunction

    assign q_imem  = rom(address_imem) ^ qXor;
    assign q_imem2 = rom(address_imem2);

    always #5 clock = ~clock;

    fetch_stage dut (
        .clock(clock), .reset(reset), .address_imem(address_imem), .q_imem(q_imem),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .fd_insn(fd_insn), .fd_pc(fd_pc), .fd_pc_plus1(fd_pc_plus1), .fd_valid(fd_valid),
        .perf_fetched(perf_fetched), .perf_stalls(perf_stalls), .perf_flushes(perf_flushes)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFF)) dutWrap (
        .clock(clock), .reset(reset), .address_imem(address_imem2), .q_imem(q_imem2),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .fd_insn(fd_insn2), .fd_pc(fd_pc2), .fd_pc_plus1(fd_pc_plus12), .fd_valid(fd_valid2),
        .perf_fetched(perf_fetched2), .perf_stalls(perf_stalls2), .perf_flushes(perf_flushes2)
    );

    // Reference model state, described in terms of the architectural rules.
    logic [31:0] mPc, mInsn, mFdPc, mFdPc1;
    logic        mValid;
    int unsigned mFetched, mStalls, mFlushes;

    task automatic step(input logic r, input logic s, input logic rd, input logic [31:0] rpc);
        @(negedge clock);
        reset = r; stall = s; redirect = rd; redirect_pc = rpc;
        qXor = (s && !rd && !r) ? $urandom() : 32'h0;
        @(posedge clock);
        if (r) begin
            mPc = 32'd0; mInsn = 0; mFdPc = 0; mFdPc1 = 0; mValid = 0;
            mFetched = 0; mStalls = 0; mFlushes = 0;
        end else if (rd) begin
            mPc = rpc; mInsn = 0; mValid = 0; mFlushes++;
        end else if (s) begin
            mStalls++;
        end else begin
            mInsn = rom(mPc); mFdPc = mPc; mFdPc1 = mPc + 1; mValid = 1; mPc = mPc + 1;
            mFetched++;
        end
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0);
        total++;
        if ({address_imem, fd_insn, fd_pc, fd_pc_plus1, fd_valid} !== {32'd0, 32'd0, 32'd0, 32'd0, 1'b0}) begin
            bad++; $display("FAIL reset_state: addr=%h insn=%h pc=%h pc1=%h v=%b expected all zero",
                            address_imem, fd_insn, fd_pc, fd_pc_plus1, fd_valid);
        end
        total++;
        if ({perf_fetched, perf_stalls, perf_flushes} !== 96'd0) begin
            bad++; $display("FAIL reset_perf: %0d %0d %0d expected 0 0 0", perf_fetched, perf_stalls, perf_flushes);
        end
    endtask

    task automatic test_free_run();
        step(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0);
            total++;
            if (fd_pc !== 32'(i) || fd_insn !== 32'(i + 'h100) || fd_valid !== 1'b1 || fd_pc_plus1 !== 32'(i + 1)) begin
                bad++; $display("FAIL free_run[%0d]: pc=%h insn=%h v=%b pc1=%h expected pc=%h insn=%h v=1 pc1=%h",
                                i, fd_pc, fd_insn, fd_valid, fd_pc_plus1, i, i + 'h100, i + 1);
            end
        end
    endtask

    task automatic test_stall();
        step(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 0, 0);
            total++;
            if (fd_pc !== 32'd5 || fd_insn !== 32'h105 || address_imem !== 32'd6 || fd_valid !== 1'b1) begin
                bad++; $display("FAIL stall_hold[%0d]: pc=%h insn=%h addr=%h v=%b expected 5 105 6 1",
                                k, fd_pc, fd_insn, address_imem, fd_valid);
            end
        end
        step(0, 0, 0, 0);
        total++;
        if (fd_pc !== 32'd6 || fd_insn !== 32'h106) begin
            bad++; $display("FAIL stall_resume: pc=%h insn=%h expected 6 106", fd_pc, fd_insn);
        end
    endtask

    task automatic test_redirect_stall();
        step(0, 1, 1, 32'h40);
        total++;
        if (fd_valid !== 1'b0 || fd_insn !== 32'h0 || address_imem !== 32'h40 || fd_pc !== 32'd6) begin
            bad++; $display("FAIL redirect_bubble: v=%b insn=%h addr=%h pc=%h expected 0 0 40 6",
                            fd_valid, fd_insn, address_imem, fd_pc);
        end
        step(0, 0, 0, 0);
        total++;
        if (fd_pc !== 32'h40 || fd_insn !== 32'h140 || fd_valid !== 1'b1 || fd_pc_plus1 !== 32'h41) begin
            bad++; $display("FAIL redirect_target: pc=%h insn=%h v=%b pc1=%h expected 40 140 1 41",
                            fd_pc, fd_insn, fd_valid, fd_pc_plus1);
        end
    endtask

    task automatic test_wrap();
        step(1, 0, 0, 0);
        total++;
        if (address_imem2 !== 32'hFFFF_FFFF || fd_valid2 !== 1'b0) begin
            bad++; $display("FAIL wrap_reset: addr=%h v=%b expected ffffffff 0", address_imem2, fd_valid2);
        end
        step(0, 0, 0, 0);
        total++;
        if (fd_pc2 !== 32'hFFFF_FFFF || fd_pc_plus12 !== 32'h0 || address_imem2 !== 32'h0 || fd_insn2 !== 32'hFF) begin
            bad++; $display("FAIL wrap_fetch: pc=%h pc1=%h addr=%h insn=%h expected ffffffff 0 0 ff",
                            fd_pc2, fd_pc_plus12, address_imem2, fd_insn2);
        end
    endtask

    task automatic test_reset_mid_stall();
        step(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(1, 1, 1, 32'h77);
        total++;
        if ({address_imem, fd_insn, fd_pc, fd_pc_plus1, fd_valid} !== {32'd0, 32'd0, 32'd0, 32'd0, 1'b0}) begin
            bad++; $display("FAIL reset_mid_stall: addr=%h insn=%h pc=%h pc1=%h v=%b expected all zero",
                            address_imem, fd_insn, fd_pc, fd_pc_plus1, fd_valid);
        end
    endtask

    task automatic test_perf();
        step(1, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
        for (int i = 0; i < 4; i++)  step(0, 1, 0, 0);
        step(0, 0, 1, 32'h20);
        step(0, 1, 1, 32'h30);
        total++;
        if (perf_fetched !== (PERF ? 32'd10 : 32'd0) || perf_stalls !== (PERF ? 32'd4 : 32'd0) ||
            perf_flushes !== (PERF ? 32'd2 : 32'd0)) begin
            bad++; $display("FAIL perf_counts: fetched=%0d stalls=%0d flushes=%0d expected %0d %0d %0d",
                            perf_fetched, perf_stalls, perf_flushes, PERF ? 10 : 0, PERF ? 4 : 0, PERF ? 2 : 0);
        end
    endtask

    task automatic test_random();
        int errs;
        logic r, s, rd;
        step(1, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 59) == 0);
            rd = ($urandom_range(0, 7) == 0);
            s  = ($urandom_range(0, 3) == 0);
            step(r, s, rd, $urandom());
            total++;
            errs = 0;
            if (address_imem !== mPc || fd_insn !== mInsn || fd_pc !== mFdPc ||
                fd_pc_plus1 !== mFdPc1 || fd_valid !== mValid) errs++;
            if (perf_fetched !== (PERF ? 32'(mFetched) : 32'd0) || perf_stalls !== (PERF ? 32'(mStalls) : 32'd0) ||
                perf_flushes !== (PERF ? 32'(mFlushes) : 32'd0)) errs++;
            if (errs != 0) begin
                bad++; $display("FAIL random[%0d]: addr=%h insn=%h pc=%h pc1=%h v=%b cnt=%0d/%0d/%0d expected %h %h %h %h %b %0d/%0d/%0d",
                                i, address_imem, fd_insn, fd_pc, fd_pc_plus1, fd_valid,
                                perf_fetched, perf_stalls, perf_flushes,
                                mPc, mInsn, mFdPc, mFdPc1, mValid,
                                PERF ? mFetched : 0, PERF ? mStalls : 0, PERF ? mFlushes : 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_stall();
        test_redirect_stall();
        test_wrap();
        test_reset_mid_stall();
        test_perf();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
